// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_pkg
// Description : Shared ALU definitions for the sequential RV32M divider:
//               operation encodings, FSM state encoding (2-bit), XLEN and
//               small helper functions that classify an operation.
// Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

   localparam int XLEN_DEF = 32;

   // Operation encodings driven on the op port.
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   // Divider FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

   // op[0] clear selects the signed flavour (DIV / REM).
   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction

   // op[1] set selects the remainder flavour (REM / REMU).
   function automatic logic is_rem_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/subtractor.sv
`default_nettype none
// ============================================================================
// Module      : subtractor
// Description : Ripple-style subtractor a - b computed as a + ~b + cin.
//               cout is the "no borrow" flag when cin = 1.
// Ports       : a, b   - WIDTH-bit operands
//               cin    - carry in (1 for a true subtraction)
//               diff   - WIDTH-bit difference
//               cout   - carry out, 1 when a >= b (unsigned) with cin = 1
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] diff,
   output logic             cout
);

   assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Sequential RV32M divider (DIV/DIVU/REM/REMU), radix-2
//               restoring algorithm, one quotient bit per cycle. A single
//               subtractor is shared between the trial subtraction (CALC)
//               and the final sign correction (SIGN).
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset
//               start  - issue request, accepted only in IDLE
//               op     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//               rs1    - dividend, sampled on accept
//               rs2    - divisor, sampled on accept
//               busy   - high in every state except IDLE
//               done   - one-cycle pulse, result valid
//               result - quotient or remainder, held until next accept
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq
   import div_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [4:0]      LAST_IT  = 5'd31;

   div_state_e      state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] rem_q, rem_d;     // partial remainder R
   logic [XLEN-1:0] quo_q, quo_d;     // dividend shifting out / quotient in, Q
   logic [XLEN-1:0] dvs_q, dvs_d;     // divisor magnitude D
   logic [4:0]      count_q, count_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [XLEN-1:0] shifted;          // S = {R[30:0], Q[31]}
   logic [XLEN-1:0] sub_a, sub_b;
   logic [XLEN-1:0] sub_diff;
   logic            sub_cout;
   logic [XLEN-1:0] sign_src;         // unsigned quotient or remainder to correct
   logic            sign_neg;
   logic [XLEN-1:0] abs_rs1, abs_rs2;
   logic            signed_op;

   assign shifted  = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
   assign sign_src = is_rem_op(op_q) ? rem_q : quo_q;
   assign sign_neg = is_rem_op(op_q) ? neg_rem_q : neg_quo_q;

   // Operand magnitudes at accept; negation done inline so the shared
   // subtractor stays dedicated to CALC/SIGN.
   assign signed_op = is_signed_op(op);
   assign abs_rs1   = (signed_op && rs1[XLEN-1]) ? (~rs1 + XLEN'(1)) : rs1;
   assign abs_rs2   = (signed_op && rs2[XLEN-1]) ? (~rs2 + XLEN'(1)) : rs2;

   // Shared subtractor input mux: trial subtract in CALC, 0 - value in SIGN.
   always_comb begin
      sub_a = shifted;
      sub_b = dvs_q;
      if (state_q == ST_SIGN) begin
         sub_a = '0;
         sub_b = sign_src;
      end
   end

   subtractor #(.WIDTH(XLEN)) u_sub (
      .a    (sub_a),
      .b    (sub_b),
      .cin  (1'b1),
      .diff (sub_diff),
      .cout (sub_cout)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      count_d   = count_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d = op;
               if (rs2 == '0) begin
                  // Divide by zero: RISC-V defined result, no iteration.
                  result_d = is_rem_op(op) ? rs1 : ALL_ONES;
                  state_d  = ST_DONE;
               end else if (signed_op && rs1 == MIN_INT && rs2 == ALL_ONES) begin
                  // Signed overflow: -2^31 / -1.
                  result_d = is_rem_op(op) ? '0 : MIN_INT;
                  state_d  = ST_DONE;
               end else begin
                  rem_d     = '0;
                  quo_d     = abs_rs1;
                  dvs_d     = abs_rs2;
                  count_d   = '0;
                  neg_quo_d = signed_op & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                  neg_rem_d = signed_op & rs1[XLEN-1];
                  state_d   = ST_CALC;
               end
            end
         end

         ST_CALC: begin
            // R[31] set means S really is a 33-bit value larger than D.
            if (rem_q[XLEN-1] | sub_cout) begin
               rem_d = sub_diff;
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = shifted;
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            count_d = count_q + 5'd1;
            if (count_q == LAST_IT) begin
               state_d = ST_SIGN;
            end
         end

         ST_SIGN: begin
            result_d = sign_neg ? sub_diff : sign_src;
            state_d  = ST_DONE;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_DIV;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         count_q   <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         count_q   <= count_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Self-checking bench for div_seq. Directed cases for the
//               documented results and latencies plus randomized operations
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   div_seq #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: RISC-V M-extension semantics from plain arithmetic.
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = int'(a);
      sb = int'(b);
      if (b == 32'd0) begin
         return (o[1]) ? a : 32'hFFFF_FFFF;
      end
      case (o)
         OP_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
         OP_REM:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
         OP_DIVU: return a / b;
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Drives one accepted start; operands are scrambled right after the edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      rs1   = $urandom;
      rs2   = $urandom;
   endtask

   // Cycle index (1 = first cycle after accept) in which done is seen.
   task automatic wait_done(output logic [31:0] res, output int lat);
      lat = -1;
      res = 32'hDEAD_BEEF;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            res = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b result=%h required busy=0 done=0 result=0", busy, done, result);
      end
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      logic [31:0] res;
      int lat;
      issue(OP_DIVU, 32'd100, 32'd7);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_accept: busy=%b required 1", busy);
      end
      wait_done(res, lat);
      checks++;
      if (res !== 32'd14 || lat != 34) begin
         failures++;
         $display("FAIL divu_100_7: result=%h cycle=%0d required 0000000e cycle 34", res, lat);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
         failures++;
         $display("FAIL after_done: busy=%b done=%b result=%h required 0 0 0000000e", busy, done, result);
      end
      issue(OP_REMU, 32'd100, 32'd7);
      wait_done(res, lat);
      checks++;
      if (res !== 32'd2 || lat != 34) begin
         failures++;
         $display("FAIL remu_100_7: result=%h cycle=%0d required 00000002 cycle 34", res, lat);
      end
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
      wait_done(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFF || lat != 34) begin
         failures++;
         $display("FAIL divu_max_1: result=%h cycle=%0d required ffffffff cycle 34", res, lat);
      end
   endtask

   task automatic test_signed();
      logic [31:0] res;
      int lat;
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFD || lat != 34) begin
         failures++;
         $display("FAIL div_m7_2: result=%h cycle=%0d required fffffffd cycle 34", res, lat);
      end
      issue(OP_REM, 32'hFFFF_FFF9, 32'd2);
      wait_done(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFF || lat != 34) begin
         failures++;
         $display("FAIL rem_m7_2: result=%h cycle=%0d required ffffffff cycle 34", res, lat);
      end
      issue(OP_REM, 32'd7, 32'hFFFF_FFFE);
      wait_done(res, lat);
      checks++;
      if (res !== 32'd1 || lat != 34) begin
         failures++;
         $display("FAIL rem_7_m2: result=%h cycle=%0d required 00000001 cycle 34", res, lat);
      end
   endtask

   task automatic test_special();
      logic [31:0] res;
      int lat;
      issue(OP_DIV, 32'd5, 32'd0);
      wait_done(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFF || lat != 1) begin
         failures++;
         $display("FAIL div_5_0: result=%h cycle=%0d required ffffffff cycle 1", res, lat);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL special_idle: busy=%b required 0 in cycle 2", busy);
      end
      issue(OP_REMU, 32'd5, 32'd0);
      wait_done(res, lat);
      checks++;
      if (res !== 32'd5 || lat != 1) begin
         failures++;
         $display("FAIL remu_5_0: result=%h cycle=%0d required 00000005 cycle 1", res, lat);
      end
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(res, lat);
      checks++;
      if (res !== 32'h8000_0000 || lat != 1) begin
         failures++;
         $display("FAIL div_overflow: result=%h cycle=%0d required 80000000 cycle 1", res, lat);
      end
      issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(res, lat);
      checks++;
      if (res !== 32'd0 || lat != 1) begin
         failures++;
         $display("FAIL rem_overflow: result=%h cycle=%0d required 00000000 cycle 1", res, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int lat;
      int lat2;
      issue(OP_DIVU, 32'd1000, 32'd10);
      lat = -1;
      res = 32'hDEAD_BEEF;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         // Stray start mid-operation must be ignored.
         if (c == 10) begin
            start = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3;
         end else if (c == 11) begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            lat = c;
            res = result;
            break;
         end
      end
      checks++;
      if (res !== 32'd100 || lat != 34) begin
         failures++;
         $display("FAIL seq_first: result=%h cycle=%0d required 00000064 cycle 34", res, lat);
      end
      // Hold start through DONE (ignored) and cycle 35 (accepted).
      start = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3;
      @(negedge clk);
      @(posedge clk);
      #1;
      start = 1'b0; rs1 = $urandom; rs2 = $urandom;
      wait_done(res, lat2);
      checks++;
      if (res !== 32'd3 || lat2 != 34) begin
         failures++;
         $display("FAIL seq_second: result=%h cycle=%0d required 00000003 cycle 69", res, (lat2 < 0) ? lat2 : lat2 + 35);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int lat;
      bit saw_done;
      issue(OP_DIVU, 32'd12345, 32'd7);
      for (int c = 1; c <= 12; c++) @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
      end
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL reset_abort: done/busy activity=1 required 0 after reset");
      end
      issue(OP_DIVU, 32'd6, 32'd4);
      wait_done(res, lat);
      checks++;
      if (res !== 32'd1 || lat != 34) begin
         failures++;
         $display("FAIL after_reset_divu_6_4: result=%h cycle=%0d required 00000001 cycle 34", res, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] res;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  o;
      int lat;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         issue(o, a, b);
         wait_done(res, lat);
         checks++;
         if (res !== ref_div(o, a, b) || lat != ref_lat(o, a, b)) begin
            failures++;
            $display("FAIL random op=%0d a=%h b=%h: result=%h cycle=%0d required %h cycle %0d",
                     o, a, b, res, lat, ref_div(o, a, b), ref_lat(o, a, b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
